// File: rtl/tl_ul_sram_target_if.sv
// TL-UL A/D channel bundle between a client (master) and a memory target (slave).
// A flows master -> slave; D flows slave -> master.
interface tl_ul_sram_target_if #(
  parameter int ADDR_BITS   = 32,
  parameter int DATA_BITS   = 64,
  parameter int SOURCE_BITS = 4,
  parameter int SINK_BITS   = 1,
  parameter int SIZE_BITS   = 3
);
  localparam int BYTES = DATA_BITS / 8;

  logic                   a_valid;
  logic                   a_ready;
  logic [2:0]             a_bits_opcode;
  logic [2:0]             a_bits_param;
  logic [SIZE_BITS-1:0]   a_bits_size;
  logic [SOURCE_BITS-1:0] a_bits_source;
  logic [ADDR_BITS-1:0]   a_bits_address;
  logic [BYTES-1:0]       a_bits_mask;
  logic [DATA_BITS-1:0]   a_bits_data;
  logic                   a_bits_corrupt;

  logic                   d_valid;
  logic                   d_ready;
  logic [2:0]             d_bits_opcode;
  logic [1:0]             d_bits_param;
  logic [SIZE_BITS-1:0]   d_bits_size;
  logic [SOURCE_BITS-1:0] d_bits_source;
  logic [SINK_BITS-1:0]   d_bits_sink;
  logic                   d_bits_denied;
  logic [DATA_BITS-1:0]   d_bits_data;
  logic                   d_bits_corrupt;

  modport master (
    output a_valid, a_bits_opcode, a_bits_param, a_bits_size, a_bits_source,
           a_bits_address, a_bits_mask, a_bits_data, a_bits_corrupt,
    input  a_ready,
    input  d_valid, d_bits_opcode, d_bits_param, d_bits_size, d_bits_source,
           d_bits_sink, d_bits_denied, d_bits_data, d_bits_corrupt,
    output d_ready
  );

  modport slave (
    input  a_valid, a_bits_opcode, a_bits_param, a_bits_size, a_bits_source,
           a_bits_address, a_bits_mask, a_bits_data, a_bits_corrupt,
    output a_ready,
    output d_valid, d_bits_opcode, d_bits_param, d_bits_size, d_bits_source,
           d_bits_sink, d_bits_denied, d_bits_data, d_bits_corrupt,
    input  d_ready
  );
endinterface

// File: rtl/tl_ul_sram_target.sv
// Single-beat TL-UL memory target: register-array memory behind an A channel,
// with in-order responses returned through a 2-entry D queue.
module tl_ul_sram_target #(
  parameter int                   ADDR_BITS   = 32,
  parameter int                   DATA_BITS   = 64,
  parameter int                   SOURCE_BITS = 4,
  parameter int                   SINK_BITS   = 1,
  parameter int                   SIZE_BITS   = 3,
  parameter logic [ADDR_BITS-1:0] BASE_ADDR   = 'h8000_0000,
  parameter int                   DEPTH       = 1024
) (
  input  logic                  clock,
  input  logic                  reset,
  tl_ul_sram_target_if.slave    tl
);
  localparam int BYTES = DATA_BITS / 8;
  localparam int OFF   = $clog2(BYTES);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_BITS-1:0] DEPTH_A = ADDR_BITS'(DEPTH);

  localparam logic [2:0] A_PUT_FULL    = 3'd0;
  localparam logic [2:0] A_PUT_PARTIAL = 3'd1;
  localparam logic [2:0] A_ARITH       = 3'd2;
  localparam logic [2:0] A_LOGIC       = 3'd3;
  localparam logic [2:0] A_GET         = 3'd4;
  localparam logic [2:0] A_INTENT      = 3'd5;

  typedef enum logic [2:0] {
    D_ACCESS_ACK      = 3'd0,
    D_ACCESS_ACK_DATA = 3'd1,
    D_HINT_ACK        = 3'd2
  } d_op_e;

  typedef struct packed {
    d_op_e                  opcode;
    logic [SIZE_BITS-1:0]   size;
    logic [SOURCE_BITS-1:0] source;
    logic                   denied;
    logic [DATA_BITS-1:0]   data;
    logic                   corrupt;
  } rsp_t;

  logic [DATA_BITS-1:0]   mem_q [DEPTH];
  rsp_t                   rsp_q [2];
  logic                   wr_ptr_q, rd_ptr_q;
  logic [1:0]             count_q, count_d;
  logic                   a_ready_q;

  logic                   fire, deq, mem_we;
  logic [ADDR_BITS-1:0]   offset;
  logic [IDX_W-1:0]       word_idx;
  logic                   in_range, aligned, legal;
  logic                   is_put, is_get, is_intent, is_atomic, denied;
  rsp_t                   rsp_new;
  logic                   unused_a_param;

  assign unused_a_param = ^tl.a_bits_param;

  assign fire = tl.a_valid && a_ready_q;
  assign deq  = (count_q != 2'd0) && tl.d_ready;

  // Request decode and response formation happen in the accept cycle.
  // NOTE: every always_comb output gets a default up front so no path can infer a latch.
  always_comb begin
    offset    = tl.a_bits_address - BASE_ADDR;
    word_idx  = offset[OFF +: IDX_W];
    in_range  = (tl.a_bits_address >= BASE_ADDR) && ((offset >> OFF) < DEPTH_A);
    aligned   = 1'b1;
    for (int i = 0; i < ADDR_BITS && i < (1 << SIZE_BITS); i++) begin
      if (i < int'(tl.a_bits_size) && tl.a_bits_address[i]) aligned = 1'b0;
    end
    legal     = aligned && (int'(tl.a_bits_size) <= OFF);
    is_put    = (tl.a_bits_opcode == A_PUT_FULL) || (tl.a_bits_opcode == A_PUT_PARTIAL);
    is_atomic = (tl.a_bits_opcode == A_ARITH) || (tl.a_bits_opcode == A_LOGIC);
    is_intent = (tl.a_bits_opcode == A_INTENT);
    is_get    = !is_put && !is_atomic && !is_intent;

    // Reserved opcodes 6/7 fall into the Get path but are always denied.
    if (is_intent) denied = !in_range;
    else           denied = !in_range || !legal || is_atomic || (tl.a_bits_opcode != A_GET && is_get);

    rsp_new        = '0;
    rsp_new.opcode = is_put ? D_ACCESS_ACK : (is_intent ? D_HINT_ACK : D_ACCESS_ACK_DATA);
    rsp_new.size   = tl.a_bits_size;
    rsp_new.source = tl.a_bits_source;
    rsp_new.denied = denied;
    rsp_new.data   = (is_get && !denied) ? mem_q[word_idx] : '0;
    rsp_new.corrupt = (rsp_new.opcode == D_ACCESS_ACK_DATA) && denied;

    mem_we = fire && is_put && !denied && !tl.a_bits_corrupt;
  end

  // NOTE: the storage array and queue payload carry no reset; only control state is reset.
  always_ff @(posedge clock) begin
    if (mem_we) begin
      for (int b = 0; b < BYTES; b++) begin
        if (tl.a_bits_mask[b]) mem_q[word_idx][8*b +: 8] <= tl.a_bits_data[8*b +: 8];
      end
    end
    if (fire) rsp_q[wr_ptr_q] <= rsp_new;
  end

  always_comb begin
    count_d = count_q;
    if (fire && !deq)      count_d = count_q + 2'd1;
    else if (!fire && deq) count_d = count_q - 2'd1;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      count_q   <= 2'd0;
      a_ready_q <= 1'b1;
    end else begin
      if (fire) wr_ptr_q <= ~wr_ptr_q;
      if (deq)  rd_ptr_q <= ~rd_ptr_q;
      count_q   <= count_d;
      a_ready_q <= (count_d != 2'd2);
    end
  end

  assign tl.a_ready        = a_ready_q;
  assign tl.d_valid        = (count_q != 2'd0);
  assign tl.d_bits_opcode  = rsp_q[rd_ptr_q].opcode;
  assign tl.d_bits_param   = 2'd0;
  assign tl.d_bits_size    = rsp_q[rd_ptr_q].size;
  assign tl.d_bits_source  = rsp_q[rd_ptr_q].source;
  assign tl.d_bits_sink    = '0;
  assign tl.d_bits_denied  = rsp_q[rd_ptr_q].denied;
  assign tl.d_bits_data    = rsp_q[rd_ptr_q].data;
  assign tl.d_bits_corrupt = rsp_q[rd_ptr_q].corrupt;
endmodule

// File: tb/tb_tl_ul_sram_target.sv
// Directed bench for tl_ul_sram_target: expected D beats are queued when A is driven
// and compared in order by a D-channel monitor.
module tb_tl_ul_sram_target;
  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam int          DEPTH = 1024;

  typedef struct {
    logic [2:0]  op;
    logic [3:0]  src;
    logic [2:0]  size;
    logic        denied;
    logic [63:0] data;
    logic        corrupt;
  } exp_t;

  logic clock;
  logic reset;
  int   tests = 0;
  int   fails = 0;
  exp_t sb[$];

  tl_ul_sram_target_if bus ();

  tl_ul_sram_target dut (
    .clock (clock),
    .reset (reset),
    .tl    (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // D monitor: sampled on the falling edge, one pop per accepted beat.
  always @(negedge clock) begin
    if (reset && bus.d_valid && bus.d_ready) begin
      tests++;
      assert (sb.size() != 0) else begin
        fails++;
        $error("FAIL d_unexpected observed=src%0h expected=no_beat", bus.d_bits_source);
      end
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        check("d_opcode",  bus.d_bits_opcode,  e.op);
        check("d_source",  bus.d_bits_source,  e.src);
        check("d_size",    bus.d_bits_size,    e.size);
        check("d_denied",  bus.d_bits_denied,  e.denied);
        check("d_data",    bus.d_bits_data,    e.data);
        check("d_corrupt", bus.d_bits_corrupt, e.corrupt);
        check("d_param",   bus.d_bits_param,   2'd0);
        check("d_sink",    bus.d_bits_sink,    1'b0);
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [2:0] op, input logic [2:0] size, input logic [3:0] src,
                      input logic [31:0] addr, input logic [7:0] mask, input logic [63:0] data,
                      input logic corrupt, input logic [2:0] exp_op, input logic exp_den,
                      input logic [63:0] exp_data);
    exp_t e;
    int   cyc;
    e.op = exp_op; e.src = src; e.size = size; e.denied = exp_den;
    e.data = exp_data; e.corrupt = (exp_op == 3'd1) && exp_den;
    sb.push_back(e);
    bus.a_valid = 1'b1; bus.a_bits_opcode = op; bus.a_bits_size = size;
    bus.a_bits_source = src; bus.a_bits_address = addr; bus.a_bits_mask = mask;
    bus.a_bits_data = data; bus.a_bits_corrupt = corrupt; bus.a_bits_param = 3'd0;
    cyc = 0;
    forever begin
      @(negedge clock);
      if (bus.a_ready) break;
      cyc++;
      if (cyc > 50) break;
    end
    if (cyc > 50) check("a_accept_timeout", 64'(cyc), 64'd0);
    @(posedge clock);
    #1 bus.a_valid = 1'b0;
  endtask

  task automatic drain();
    int cyc;
    cyc = 0;
    while (sb.size() != 0 && cyc < 50) begin
      @(negedge clock);
      cyc++;
    end
    check("drain_pending", 64'(sb.size()), 64'd0);
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    bus.a_valid = 1'b0; bus.a_bits_opcode = '0; bus.a_bits_param = '0; bus.a_bits_size = '0;
    bus.a_bits_source = '0; bus.a_bits_address = '0; bus.a_bits_mask = '0;
    bus.a_bits_data = '0; bus.a_bits_corrupt = 1'b0; bus.d_ready = 1'b1;

    #1 check("reset_d_valid", bus.d_valid, 1'b0);
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;
    @(negedge clock);
    check("post_reset_a_ready", bus.a_ready, 1'b1);
    check("post_reset_d_valid", bus.d_valid, 1'b0);
    @(posedge clock); #1;

    // PutFull then Get; response appears right after the accepting edge.
    send(3'd0, 3'd3, 4'd3, BASE, 8'hFF, 64'hDEADBEEF_CAFEF00D, 1'b0, 3'd0, 1'b0, 64'd0);
    @(negedge clock);
    check("put_latency_d_valid", bus.d_valid, 1'b1);
    @(posedge clock); #1;
    send(3'd4, 3'd3, 4'd5, BASE, 8'hFF, 64'd0, 1'b0, 3'd1, 1'b0, 64'hDEADBEEF_CAFEF00D);
    drain();

    // PutPartial followed by a back-to-back Get (read-after-write).
    send(3'd1, 3'd3, 4'd6, BASE, 8'h0F, 64'h11223344_55667788, 1'b0, 3'd0, 1'b0, 64'd0);
    send(3'd4, 3'd3, 4'd7, BASE, 8'hFF, 64'd0, 1'b0, 3'd1, 1'b0, 64'hDEADBEEF_55667788);
    drain();

    // Out-of-range Gets above and below the window.
    send(3'd4, 3'd3, 4'd1, BASE + DEPTH * 8, 8'hFF, 64'd0, 1'b0, 3'd1, 1'b1, 64'd0);
    send(3'd4, 3'd3, 4'd2, BASE - 32'd8, 8'hFF, 64'd0, 1'b0, 3'd1, 1'b1, 64'd0);
    drain();

    // Illegal size, misaligned put, corrupt put, atomic, reserved opcode, hints.
    send(3'd4, 3'd4, 4'd4, BASE, 8'hFF, 64'd0, 1'b0, 3'd1, 1'b1, 64'd0);
    send(3'd0, 3'd2, 4'd8, BASE + 32'd2, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 3'd0, 1'b1, 64'd0);
    send(3'd0, 3'd3, 4'd9, BASE, 8'hFF, 64'h0, 1'b1, 3'd0, 1'b0, 64'd0);
    send(3'd2, 3'd3, 4'd10, BASE, 8'hFF, 64'h1, 1'b0, 3'd1, 1'b1, 64'd0);
    send(3'd6, 3'd3, 4'd11, BASE, 8'hFF, 64'h0, 1'b0, 3'd1, 1'b1, 64'd0);
    send(3'd5, 3'd3, 4'd12, BASE + 32'd8, 8'hFF, 64'h0, 1'b0, 3'd2, 1'b0, 64'd0);
    send(3'd5, 3'd3, 4'd13, BASE - 32'd8, 8'hFF, 64'h0, 1'b0, 3'd2, 1'b1, 64'd0);
    send(3'd4, 3'd3, 4'd14, BASE, 8'hFF, 64'd0, 1'b0, 3'd1, 1'b0, 64'hDEADBEEF_55667788);
    drain();

    // Backpressure: third Get must wait until the full queue drains.
    bus.d_ready = 1'b0;
    fork
      begin
        send(3'd4, 3'd3, 4'd1, BASE, 8'hFF, 64'd0, 1'b0, 3'd1, 1'b0, 64'hDEADBEEF_55667788);
        send(3'd4, 3'd3, 4'd2, BASE, 8'hFF, 64'd0, 1'b0, 3'd1, 1'b0, 64'hDEADBEEF_55667788);
        send(3'd4, 3'd3, 4'd3, BASE, 8'hFF, 64'd0, 1'b0, 3'd1, 1'b0, 64'hDEADBEEF_55667788);
      end
      begin
        repeat (4) @(negedge clock);
        check("full_a_ready", bus.a_ready, 1'b0);
        check("full_d_valid", bus.d_valid, 1'b1);
        check("stall_hold_source", bus.d_bits_source, 4'd1);
        @(negedge clock);
        check("stall_hold_source_2", bus.d_bits_source, 4'd1);
        @(posedge clock);
        #1 bus.d_ready = 1'b1;
      end
    join
    drain();

    // Reset with two responses pending: they are dropped, memory survives.
    bus.d_ready = 1'b0;
    send(3'd4, 3'd3, 4'd7, BASE, 8'hFF, 64'd0, 1'b0, 3'd1, 1'b0, 64'hDEADBEEF_55667788);
    send(3'd4, 3'd3, 4'd8, BASE, 8'hFF, 64'd0, 1'b0, 3'd1, 1'b0, 64'hDEADBEEF_55667788);
    @(negedge clock);
    check("pre_reset_d_valid", bus.d_valid, 1'b1);
    check("pre_reset_a_ready", bus.a_ready, 1'b0);
    @(posedge clock);
    #2 reset = 1'b0;
    #1 check("async_reset_d_valid", bus.d_valid, 1'b0);
    sb.delete();
    @(posedge clock);
    #1 reset = 1'b1;
    @(negedge clock);
    check("release_a_ready", bus.a_ready, 1'b1);
    check("release_d_valid", bus.d_valid, 1'b0);
    @(posedge clock);
    #1 bus.d_ready = 1'b1;
    send(3'd4, 3'd3, 4'd15, BASE, 8'hFF, 64'd0, 1'b0, 3'd1, 1'b0, 64'hDEADBEEF_55667788);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
